// File: rtl/oddr_serializer.sv
// Multi-lane DDR output serializer: buffered words leave LSB first as rise/fall pairs per lane.
// Optional ODDR_SER_TRAIN_EN adds a train input that drives a forwarded-clock pattern while idle.
module oddr_serializer #(
  parameter int   LANES      = 4,
  parameter int   RATIO      = 8,
  parameter int   FIFO_DEPTH = 2,
  parameter logic IDLE_VAL   = 1'b0
) (
  input  logic                             clk,
  input  logic                             resetb,
  input  logic                             ce,
  input  logic                             srst,
  input  logic                             sset,
`ifdef ODDR_SER_TRAIN_EN
  input  logic                             train,
`endif
  input  logic [LANES*RATIO-1:0]           din,
  input  logic                             din_valid,
  output logic                             din_ready,
  output logic [LANES-1:0]                 rise,
  output logic [LANES-1:0]                 fall,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int BEATS = RATIO / 2;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int WW    = LANES * RATIO;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [WW-1:0]     shift_q, shift_d;
  logic [LANES-1:0]  rise_d, fall_d;
  logic              busy_d;
  logic [WW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic [WW-1:0]     head;
  logic              push, pop, full, nonempty, last_beat, train_on;
  logic [LANES-1:0]  idle_rise, idle_fall;

`ifdef ODDR_SER_TRAIN_EN
  assign train_on = train;
`else
  assign train_on = 1'b0;
`endif

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign nonempty   = (count_q != '0);
  assign din_ready  = ce & ~full & ~srst;
  assign push       = din_valid & din_ready;
  assign head       = mem[rd_ptr];
  assign last_beat  = (beat_q == BW'(BEATS - 1));
  assign idle_rise  = train_on ? '1 : {LANES{IDLE_VAL}};
  assign idle_fall  = train_on ? '0 : {LANES{IDLE_VAL}};
  assign fifo_level = count_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shift_d = shift_q;
    rise_d  = rise;
    fall_d  = fall;
    busy_d  = busy;
    pop     = 1'b0;
    if (srst) begin
      state_d = IDLE;
      beat_d  = '0;
      shift_d = '0;
      rise_d  = {LANES{IDLE_VAL}};
      fall_d  = {LANES{IDLE_VAL}};
      busy_d  = 1'b0;
    end else if (sset) begin
      rise_d = '1;
      fall_d = '1;
    end else if (ce) begin
      // A pop happens from IDLE or on the last beat, which keeps words seamless.
      if ((state_q == IDLE) || last_beat) begin
        if (nonempty) begin
          pop     = 1'b1;
          state_d = SHIFT;
          beat_d  = '0;
          busy_d  = 1'b1;
          for (int l = 0; l < LANES; l++) begin
            rise_d[l]                  = head[l*RATIO];
            fall_d[l]                  = head[l*RATIO+1];
            shift_d[l*RATIO +: RATIO]  = head[l*RATIO +: RATIO] >> 2;
          end
        end else begin
          state_d = IDLE;
          beat_d  = '0;
          busy_d  = 1'b0;
          rise_d  = idle_rise;
          fall_d  = idle_fall;
        end
      end else begin
        beat_d = beat_q + BW'(1);
        for (int l = 0; l < LANES; l++) begin
          rise_d[l]                  = shift_q[l*RATIO];
          fall_d[l]                  = shift_q[l*RATIO+1];
          shift_d[l*RATIO +: RATIO]  = shift_q[l*RATIO +: RATIO] >> 2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      rise    <= {LANES{IDLE_VAL}};
      fall    <= {LANES{IDLE_VAL}};
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
      rise    <= rise_d;
      fall    <= fall_d;
      busy    <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (srst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_oddr_serializer.sv
// Self-checking bench for oddr_serializer (LANES=2, RATIO=4, FIFO_DEPTH=2, IDLE_VAL=0).
// Reference model: queue of buffered words plus index of the beat on display.
module tb_oddr_serializer;
  localparam int L = 2, R = 4, D = 2, B = R / 2;

  logic clk = 1'b0, resetb = 1'b0, ce = 1'b0, srst = 1'b0, sset = 1'b0, train = 1'b0;
  logic [L*R-1:0] din = '0;
  logic din_valid = 1'b0, din_ready, busy;
  logic [L-1:0] rise, fall;
  logic [1:0] fifo_level;

  oddr_serializer #(.LANES(L), .RATIO(R), .FIFO_DEPTH(D), .IDLE_VAL(1'b0)) dut (
    .clk(clk), .resetb(resetb), .ce(ce), .srst(srst), .sset(sset),
`ifdef ODDR_SER_TRAIN_EN
    .train(train),
`endif
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .rise(rise), .fall(fall), .busy(busy), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // model state
  logic [L*R-1:0] fq[$];
  logic [L*R-1:0] cur;
  int k = -1;
  logic [L-1:0] er = '0, ef = '0;
  logic eb = 1'b0;
  logic exp_ready, obs_ready, m_pushed;
  logic [1:0] obs_level;

  function automatic logic [L-1:0] bits(input logic [L*R-1:0] w, input int pos);
    logic [L-1:0] b;
    for (int l = 0; l < L; l++) b[l] = w[l*R + pos];
    return b;
  endfunction

  task automatic m_reset();
    fq.delete(); k = -1; er = '0; ef = '0; eb = 1'b0;
  endtask

  // One clock: captures pre-edge ready/level, advances the model, returns 1 after the edge.
  task automatic tick();
    logic [L*R-1:0] w;
    logic tr;
    #2;
    obs_ready = din_ready;
    obs_level = fifo_level;
    exp_ready = ce && (fq.size() < D) && !srst;
    m_pushed  = exp_ready && din_valid;
    w = din;
`ifdef ODDR_SER_TRAIN_EN
    tr = train;
`else
    tr = 1'b0;
`endif
    @(posedge clk);
    if (srst) begin
      fq.delete(); k = -1; er = '0; ef = '0;
    end else if (sset) begin
      er = '1; ef = '1;
    end else if (ce) begin
      if (k < 0 || k == B - 1) begin
        if (fq.size() > 0) begin
          cur = fq.pop_front(); k = 0;
          er = bits(cur, 0); ef = bits(cur, 1);
        end else begin
          k = -1;
          er = tr ? '1 : '0; ef = '0;
        end
      end else begin
        k++;
        er = bits(cur, 2*k); ef = bits(cur, 2*k + 1);
      end
    end
    eb = (k >= 0);
    if (m_pushed) fq.push_back(w);
    #1;
  endtask

  task automatic test_reset();
    resetb = 1'b0; ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      srst = 1'($urandom); sset = 1'($urandom); din_valid = 1'($urandom); din = 8'($urandom);
      train = 1'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (rise !== 2'b00 || fall !== 2'b00 || busy !== 1'b0 || fifo_level !== 2'd0 || din_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: rise=%b fall=%b busy=%b lvl=%0d rdy=%b, want 00 00 0 0 0",
                 rise, fall, busy, fifo_level, din_ready);
      end
    end
    srst = 0; sset = 0; din_valid = 0; train = 0; ce = 1;
    resetb = 1'b1;
    m_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [L-1:0] wr[3], wf[3];
    logic wb[3];
    wr[0] = 2'b10; wf[0] = 2'b11; wb[0] = 1;
    wr[1] = 2'b01; wf[1] = 2'b10; wb[1] = 1;
    wr[2] = 2'b00; wf[2] = 2'b00; wb[2] = 0;
    din = 8'b1011_0110; din_valid = 1;
    tick();
    din_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (rise !== wr[i] || fall !== wf[i] || busy !== wb[i]) begin
        miscompares++;
        $display("FAIL single beat%0d: rise=%b fall=%b busy=%b, want %b %b %b",
                 i, rise, fall, busy, wr[i], wf[i], wb[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, bcnt = 0, first = -1, last = -1;
    din = 8'($urandom); din_valid = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_pushed) begin
        acc++;
        if (acc == 3) din_valid = 0; else din = 8'($urandom);
      end
      vectors++;
      if (rise !== er || fall !== ef || busy !== eb || fifo_level !== 2'(fq.size()) || obs_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL b2b cyc%0d: rise=%b fall=%b busy=%b lvl=%0d rdy=%b, want %b %b %b %0d %b",
                 c, rise, fall, busy, fifo_level, obs_ready, er, ef, eb, fq.size(), exp_ready);
      end
      if (obs_level == 2'd2) begin
        vectors++;
        if (obs_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_full_ready: rdy=%b, want 0", obs_ready);
        end
      end
      if (busy) begin
        bcnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    vectors++;
    if (bcnt != 6 || (last - first + 1) != 6 || acc != 3) begin
      miscompares++;
      $display("FAIL b2b_contiguous: busy_cycles=%0d span=%0d accepted=%0d, want 6 6 3",
               bcnt, last - first + 1, acc);
    end
  endtask

  task automatic test_ce_hold();
    logic [L-1:0] hr, hf;
    logic [1:0] hl;
    din = 8'($urandom); din_valid = 1;
    tick();
    din = 8'($urandom);
    tick();
    din_valid = 0;
    tick();
    hr = rise; hf = fall; hl = fifo_level;
    ce = 0; din_valid = 1; din = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (rise !== hr || fall !== hf || fifo_level !== hl || obs_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL ce_hold%0d: rise=%b fall=%b lvl=%0d rdy=%b busy=%b, want %b %b %0d 0 1",
                 i, rise, fall, fifo_level, obs_ready, busy, hr, hf, hl);
      end
    end
    ce = 1; din_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (rise !== er || fall !== ef || busy !== eb || fifo_level !== 2'(fq.size())) begin
        miscompares++;
        $display("FAIL ce_resume%0d: rise=%b fall=%b busy=%b lvl=%0d, want %b %b %b %0d",
                 i, rise, fall, busy, fifo_level, er, ef, eb, fq.size());
      end
    end
  endtask

  task automatic test_srst();
    din = 8'($urandom); din_valid = 1;
    tick();
    din = 8'($urandom);
    tick();
    sset = 1; din = 8'($urandom);
    tick();
    vectors++;
    if (rise !== 2'b11 || fall !== 2'b11 || fifo_level !== 2'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sset_freeze: rise=%b fall=%b lvl=%0d busy=%b, want 11 11 2 1", rise, fall, fifo_level, busy);
    end
    sset = 0; srst = 1; din_valid = 0;
    tick();
    vectors++;
    if (rise !== 2'b00 || fall !== 2'b00 || busy !== 1'b0 || fifo_level !== 2'd0) begin
      miscompares++;
      $display("FAIL srst: rise=%b fall=%b busy=%b lvl=%0d, want 00 00 0 0", rise, fall, busy, fifo_level);
    end
    sset = 1;
    tick();
    vectors++;
    if (rise !== 2'b00 || fall !== 2'b00) begin
      miscompares++;
      $display("FAIL srst_sset: rise=%b fall=%b, want 00 00", rise, fall);
    end
    srst = 0; sset = 0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      ce        = ($urandom_range(0, 9) != 0);
      srst      = ($urandom_range(0, 24) == 0);
      sset      = ($urandom_range(0, 14) == 0);
      din_valid = 1'($urandom);
      din       = 8'($urandom);
      tick();
      vectors++;
      if (rise !== er || fall !== ef || busy !== eb || fifo_level !== 2'(fq.size()) || obs_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL random cyc%0d: rise=%b fall=%b busy=%b lvl=%0d rdy=%b, want %b %b %b %0d %b",
                 c, rise, fall, busy, fifo_level, obs_ready, er, ef, eb, fq.size(), exp_ready);
      end
    end
    ce = 1; srst = 1; sset = 0; din_valid = 0;
    tick();
    srst = 0;
  endtask

`ifdef ODDR_SER_TRAIN_EN
  task automatic test_train();
    train = 1;
    tick();
    vectors++;
    if (rise !== 2'b11 || fall !== 2'b00) begin
      miscompares++;
      $display("FAIL train_idle: rise=%b fall=%b, want 11 00", rise, fall);
    end
    din = 8'($urandom); din_valid = 1;
    tick();
    din_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (rise !== er || fall !== ef || busy !== eb) begin
        miscompares++;
        $display("FAIL train_word%0d: rise=%b fall=%b busy=%b, want %b %b %b", i, rise, fall, busy, er, ef, eb);
      end
    end
    vectors++;
    if (rise !== 2'b11 || fall !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL train_return: rise=%b fall=%b busy=%b, want 11 00 0", rise, fall, busy);
    end
    train = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ce_hold();
    test_srst();
    test_random();
`ifdef ODDR_SER_TRAIN_EN
    test_train();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end
endmodule
